// File: rtl/s2p_deserializer.sv
// Serial-to-parallel converter: strobed serial bits -> W-bit word in a valid/ready holding register.
// Optional even-parity frame (W data + 1 parity bit, adds parity_err) under macro PARITY_EN.
module s2p_deserializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sin,
    input  logic              sync,
    output logic [2**N-1:0]   y,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    input  logic              clr_ovr
`ifdef PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int W = 2**N;
`ifdef PARITY_EN
    localparam int CW   = N + 1;
    localparam int LAST = W;
`else
    localparam int CW   = N;
    localparam int LAST = W - 1;
`endif

    typedef enum logic {SHIFT, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sr, sr_shift, sr_seed, word;
    logic [CW-1:0]  cnt;
    logic           complete, load, drop;
`ifdef PARITY_EN
    logic           perr_word;
`endif

    always_comb begin
        sr_shift = MSB_FIRST ? {sr[W-2:0], sin} : {sin, sr[W-1:1]};
        sr_seed  = MSB_FIRST ? {{(W-1){1'b0}}, sin} : {sin, {(W-1){1'b0}}};
        // sync overrides completion: the frame is abandoned, nothing is transferred
        complete = en && !sync && (cnt == CW'(LAST));
`ifdef PARITY_EN
        word      = sr;
        perr_word = (^sr) ^ sin;
`else
        word      = sr_shift;
`endif
        load = complete && (!valid || ready);
        drop = complete && valid && !ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (sync) begin
            sr  <= en ? sr_seed : '0;
            cnt <= en ? CW'(1) : '0;
        end else if (en) begin
            cnt <= complete ? '0 : cnt + CW'(1);
`ifdef PARITY_EN
            // the parity bit is not part of the data word
            if (!complete)
                sr <= sr_shift;
`else
            sr <= sr_shift;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (load) begin
                y     <= word;
                valid <= 1'b1;
`ifdef PARITY_EN
                parity_err <= perr_word;
`endif
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (drop)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= SHIFT;
        else
            state_q <= state_d;
    end

    // FLUSH only marks that a sync arrived while a word was stalled downstream
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHIFT: if (sync && valid && !ready) state_d = FLUSH;
            FLUSH: if (valid && ready)          state_d = SHIFT;
            default:                            state_d = SHIFT;
        endcase
    end

endmodule

// File: doc/s2p_deserializer.md
Name: s2p_deserializer

Overview:
- Parametrised serial-to-parallel converter and the successor to the fixed 16-bit clock-enabled register bank.
- Shifts a serial bit stream in on qualified clock enables and counts bits per word.
- Transfers each completed word into a clock-enabled output holding register and presents it with a valid/ready handshake.
- Sits between serial line front-ends and the parallel datapath of the S2P subsystem.

Parameters:
- N, 4, log2 of word width; W = 2**N data bits (default 16).
- MSB_FIRST, 1, 1 = first received bit lands in y[W-1]; 0 = first bit lands in y[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  serial bit strobe; sin is sampled only on cycles with en=1.
- sin  input  1  serial data bit.
- sync  input  1  word-boundary restart; clears the bit counter and partial word.
- y  output  W  parallel word (holding register).
- valid  output  1  y holds an unconsumed word.
- ready  input  1  downstream accepts y when valid&ready.
- overrun  output  1  sticky: a completed word was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst=1): shift register=0, bit counter=0, y=0, valid=0, overrun=0, state=SHIFT.
- Shift: on en=1, sin enters the shift register (MSB_FIRST=1: shift left, sin into bit 0; MSB_FIRST=0: shift right, sin into bit W-1); counter increments, width N bits, wraps W-1 -> 0.
- Completion: en=1 with counter=W-1. The word formed including this bit is the completed word.
- Transfer rule on completion cycle:
  - valid=0, or valid=1 and ready=1: y <= completed word, valid=1 next cycle. Latency: 1 clk after the last en bit.
  - valid=1 and ready=0: completed word is discarded, y holds, overrun <= 1.
- Handshake: valid=1 and ready=1 with no completion: valid <= 0 next cycle, y holds its value. y never changes while valid=1 and ready=0.
- sync=1: counter <= 0, shift register <= 0 next cycle. If en=1 in the same cycle, that bit is taken as bit 0 of the new word (counter <= 1).
- sync=1 coincident with completion: sync wins; no transfer and no overrun.
- overrun: set on a dropped word and held until clr_ovr=1. If set and clear occur in the same cycle, set wins.
- en=0: no shift and no count; the handshake still operates.
- Reset mid-word: partial word is lost and counting restarts at bit 0 after rst deasserts.
- Two-state FSM:
  - SHIFT: normal operation.
  - FLUSH: entered on sync while valid=1 and ready=0. Shifting continues. Return to SHIFT on the first valid&ready.
  - FLUSH affects only a status-free ordering guarantee: a word completed while in FLUSH is treated per the transfer rule above.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Frame is W data bits plus 1 even-parity bit; counter runs 0..W and wraps after W.
  - Completion occurs on the parity bit.
  - Adds output parity_err (1 bit). It is registered alongside y: 1 when XOR of data and parity bit is 1, loaded only when y loads, cleared on reset.
  - A word with bad parity is still delivered.
- Undefined: no parity bit, no parity_err port, frame is exactly W bits.

Test Plan:
- N=4, MSB_FIRST=1: shift 16'hA5C3 MSB first with en=1 every cycle, ready=1 -> y=16'hA5C3, valid high for 1 cycle, 1 clk after the 16th bit; overrun=0.
- MSB_FIRST=0: shift 16'hA5C3 LSB first with en toggling every other cycle -> y=16'hA5C3; no shift or count on en=0 cycles.
- ready=0: send 16'h1234 then 16'h5678 -> y stays 16'h1234, valid=1, overrun=1; pulse clr_ovr -> overrun=0; ready=1 -> valid=0 next cycle.
- Completion of 16'hBEEF with valid=1 and ready=1 in the same cycle -> old word consumed, y=16'hBEEF, valid stays 1, overrun=0.
- 7 bits shifted, then sync=1 with en=1 and sin=1, then 15 more bits of 16'hFFFF -> y=16'hFFFF; the partial 7 bits are discarded.
- rst asserted after bit 9 of a word -> y=0, valid=0 immediately (async); next 16 bits 16'h00FF -> y=16'h00FF. With PARITY_EN: 16'h0001 sent with parity bit 0 -> parity_err=1.
